// File: rtl/screen_pkg.sv
// Shared screen codes, keycodes and pick geometry for the
// screen sequencer.
package screen_pkg;

  typedef enum logic [2:0] {
    TITLE = 3'b000,
    TUNE  = 3'b001,
    PLAY  = 3'b010,
    DONE  = 3'b111
  } screen_t;

  localparam logic [7:0] ENTER = 8'h28;
  localparam logic [7:0] ESC   = 8'h29;
  localparam logic [7:0] W     = 8'h1A;
  localparam logic [7:0] S     = 8'h16;
  localparam logic [7:0] A     = 8'h04;
  localparam logic [7:0] D     = 8'h07;

  localparam int PICK_Y0 = 240;
  localparam int PICK_X0 = 320;
  localparam int Y_MIN   = 140;
  localparam int Y_MAX   = 340;
  localparam int X_MIN   = 220;
  localparam int X_MAX   = 420;

  // Overshooting steps land exactly on the bound.
  function automatic logic [9:0] clampStep(
    logic [9:0] p,
    int         delta,
    int         lo,
    int         hi
  );
    int v;
    v = int'(p) + delta;
    if (v < lo)
      v = lo;
    else if (v > hi)
      v = hi;
    return 10'(v);
  endfunction

  function automatic logic nearTarget(
    logic [9:0] p,
    int         t,
    int         tol
  );
    logic signed [10:0] d;
    d = $signed({1'b0, p}) - 11'(t);
    if (d < 11'sd0)
      d = -d;
    return (d <= 11'(tol));
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the held keycode and pulses on fresh ENTER/ESC
// presses.
module key_edge_detect
  import screen_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       enterEv,
  output logic       escEv
);

  logic [7:0] prevKey;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)
      prevKey <= 8'h00;
    else
      prevKey <= keycode;
  end

  assign enterEv = (keycode == ENTER) && (prevKey != ENTER);
  assign escEv   = (keycode == ESC) && (prevKey != ESC);

endmodule

// File: rtl/screen_sequencer.sv
// Title/tune/play/done screen FSM with pick tuning and lock
// detection, advancing once per frame.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int STEP        = 2,
  parameter int TARGET_X    = 380,
  parameter int TARGET_Y    = 200,
  parameter int TOL         = 4,
  parameter int LOCK_FRAMES = 60,
  parameter int DONE_FRAMES = 180
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic [7:0] keycode,
  output logic [2:0] currScreen,
  output logic [9:0] PickY,
  output logic [9:0] pickLRx,
  output logic       close,
  output logic [5:0] lock_cnt
);

  localparam logic [5:0] LOCK_W = 6'(LOCK_FRAMES);
  localparam logic [7:0] DONE_W = 8'(DONE_FRAMES);

  screen_t    state, stateN;
  logic [9:0] pickYN, pickXN;
  logic       closeN;
  logic [5:0] lockN, lockInc;
  logic [7:0] doneCnt, doneN, doneInc;
  logic       pendEnt, pendEsc, pendEntN, pendEscN;
  logic       enterEv, escEv, entP, escP;
  int         dy, dx;

  key_edge_detect u_keys (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .keycode(keycode),
    .enterEv(enterEv),
    .escEv  (escEv)
  );

  // Same-cycle events count toward this frame.
  assign entP = pendEnt | enterEv;
  assign escP = pendEsc | escEv;

  always_comb begin
    stateN   = state;
    pickYN   = PickY;
    pickXN   = pickLRx;
    closeN   = close;
    lockN    = lock_cnt;
    doneN    = doneCnt;
    pendEntN = entP;
    pendEscN = escP;
    dy       = 0;
    dx       = 0;
    doneInc  = doneCnt + 8'd1;
    if (!close)
      lockInc = 6'd0;
    else if (lock_cnt == LOCK_W)
      lockInc = lock_cnt;
    else
      lockInc = lock_cnt + 6'd1;
    unique case (1'b1)
      (keycode == W): dy = -STEP;
      (keycode == S): dy = STEP;
      (keycode == A): dx = -STEP;
      (keycode == D): dx = STEP;
      default: ;
    endcase
    if (frame_start) begin
      pendEntN = 1'b0;
      pendEscN = 1'b0;
      lockN    = lockInc;
      if (state == TUNE) begin
        pickYN = clampStep(PickY, dy, Y_MIN, Y_MAX);
        pickXN = clampStep(pickLRx, dx, X_MIN, X_MAX);
      end
      if (state == DONE)
        doneN = doneInc;
      if (escP) begin
        stateN = TITLE;
      end else begin
        unique case (state)
          TITLE: if (entP) stateN = TUNE;
          TUNE:  if (lockInc == LOCK_W) stateN = PLAY;
          PLAY:  if (entP) stateN = DONE;
          DONE:  if (doneInc == DONE_W) stateN = TITLE;
          default: stateN = TITLE;
        endcase
      end
      if (stateN == TUNE && state != TUNE) begin
        pickYN = 10'(PICK_Y0);
        pickXN = 10'(PICK_X0);
        lockN  = 6'd0;
      end
      if (stateN == DONE && state != DONE)
        doneN = 8'd0;
      closeN = (stateN == TUNE)
             && nearTarget(pickYN, TARGET_Y, TOL)
             && nearTarget(pickXN, TARGET_X, TOL);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= TITLE;
      PickY    <= 10'(PICK_Y0);
      pickLRx  <= 10'(PICK_X0);
      close    <= 1'b0;
      lock_cnt <= 6'd0;
      doneCnt  <= 8'd0;
      pendEnt  <= 1'b0;
      pendEsc  <= 1'b0;
    end else begin
      state    <= stateN;
      PickY    <= pickYN;
      pickLRx  <= pickXN;
      close    <= closeN;
      lock_cnt <= lockN;
      doneCnt  <= doneN;
      pendEnt  <= pendEntN;
      pendEsc  <= pendEscN;
    end
  end

  assign currScreen = state;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed and randomized checks of screen_sequencer against
// a frame-level behavioural model.
module tb_screen_sequencer;

  localparam int M_TITLE = 0;
  localparam int M_TUNE  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_DONE  = 7;
  localparam int STEPV   = 2;
  localparam int LOCKF   = 60;
  localparam int DONEF   = 180;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       frame_start;
  logic [7:0] keycode;
  logic [2:0] currScreen;
  logic [9:0] PickY;
  logic [9:0] pickLRx;
  logic       close;
  logic [5:0] lock_cnt;

  int tests = 0;
  int fails = 0;

  int         mState, mY, mX, mLock, mDone;
  bit         mClose, mPendEnt, mPendEsc;
  logic [7:0] mPrev;

  always #5 CLK = ~CLK;

  screen_sequencer dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .keycode    (keycode),
    .currScreen (currScreen),
    .PickY      (PickY),
    .pickLRx    (pickLRx),
    .close      (close),
    .lock_cnt   (lock_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".screen"}, 16'(currScreen), 16'(mState));
    chk({tag, ".pickY"}, 16'(PickY), 16'(mY));
    chk({tag, ".pickX"}, 16'(pickLRx), 16'(mX));
    chk({tag, ".close"}, 16'(close), 16'(mClose));
    if (mState == M_TUNE)
      chk({tag, ".lock"}, 16'(lock_cnt), 16'(mLock));
  endtask

  function automatic int clampI(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absI(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelReset();
    mState = M_TITLE; mY = 240; mX = 320;
    mClose = 0; mLock = 0; mDone = 0;
    mPendEnt = 0; mPendEsc = 0; mPrev = 8'h00;
  endtask

  task automatic modelStep(input bit fs, input logic [7:0] k);
    bit entEv, escEv, ent, esc;
    int nxt, nl, nd;
    entEv = (k == 8'h28) && (mPrev != 8'h28);
    escEv = (k == 8'h29) && (mPrev != 8'h29);
    mPrev = k;
    ent = mPendEnt || entEv;
    esc = mPendEsc || escEv;
    if (!fs) begin
      mPendEnt = ent;
      mPendEsc = esc;
    end else begin
      nl = mClose ? ((mLock + 1 > LOCKF) ? LOCKF : mLock + 1) : 0;
      nd = (mState == M_DONE) ? mDone + 1 : mDone;
      if (mState == M_TUNE) begin
        if (k == 8'h1A) mY = clampI(mY - STEPV, 140, 340);
        if (k == 8'h16) mY = clampI(mY + STEPV, 140, 340);
        if (k == 8'h04) mX = clampI(mX - STEPV, 220, 420);
        if (k == 8'h07) mX = clampI(mX + STEPV, 220, 420);
      end
      nxt = mState;
      if (esc) nxt = M_TITLE;
      else if (mState == M_TITLE && ent) nxt = M_TUNE;
      else if (mState == M_TUNE && nl == LOCKF) nxt = M_PLAY;
      else if (mState == M_PLAY && ent) nxt = M_DONE;
      else if (mState == M_DONE && nd == DONEF) nxt = M_TITLE;
      if (nxt == M_TUNE && mState != M_TUNE) begin
        mY = 240; mX = 320; nl = 0;
      end
      if (nxt == M_DONE && mState != M_DONE) nd = 0;
      mClose = (nxt == M_TUNE) && absI(mY - 200) <= 4
               && absI(mX - 380) <= 4;
      mLock = nl; mDone = nd; mState = nxt;
      mPendEnt = 0; mPendEsc = 0;
    end
  endtask

  task automatic cyc(input bit fs, input logic [7:0] k);
    frame_start = fs;
    keycode = k;
    modelStep(fs, k);
    @(posedge CLK);
    #1;
    checkAll("cyc");
  endtask

  task automatic frame(input logic [7:0] k);
    cyc(1'b1, k);
    cyc(1'b0, k);
    cyc(1'b0, k);
  endtask

  task automatic pulseReset();
    frame_start = 0;
    keycode = 8'h00;
    #2 Reset_n = 0;
    #1;
    modelReset();
    checkAll("rstAsync");
    @(posedge CLK);
    #1;
    checkAll("rstHold");
    Reset_n = 1;
  endtask

  task automatic goToPlay();
    repeat (20) frame(8'h1A);
    repeat (30) frame(8'h07);
    for (int i = 0; i < 80 && mState != M_PLAY; i++)
      frame(8'h00);
    chk("reachPlay", 16'(currScreen), 16'h2);
  endtask

  logic [7:0] keyTab [8] = '{8'h00, 8'h28, 8'h29, 8'h1A,
                             8'h16, 8'h04, 8'h07, 8'h55};
  logic [7:0] rk;

  initial begin
    Reset_n = 0;
    frame_start = 0;
    keycode = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    modelReset();
    checkAll("reset");
    chk("resetScreen", 16'(currScreen), 16'h0);
    chk("resetY", 16'(PickY), 16'd240);
    chk("resetX", 16'(pickLRx), 16'd320);
    Reset_n = 1;

    cyc(1'b0, 8'h28);
    cyc(1'b0, 8'h28);
    chk("preFrame", 16'(currScreen), 16'h0);
    cyc(1'b1, 8'h28);
    chk("enterTune", 16'(currScreen), 16'h1);
    frame(8'h00);
    frame(8'h00);
    chk("tuneY", 16'(PickY), 16'd240);
    chk("tuneX", 16'(pickLRx), 16'd320);

    repeat (60) frame(8'h1A);
    chk("clampTop", 16'(PickY), 16'd140);

    repeat (30) frame(8'h16);
    repeat (30) frame(8'h07);
    frame(8'h00);
    chk("closeOn", 16'(close), 16'h1);
    repeat (29) frame(8'h00);
    repeat (3) frame(8'h04);
    frame(8'h07);
    chk("lockDrop", 16'(lock_cnt), 16'h0);
    repeat (2) frame(8'h07);
    for (int i = 0; i < 80 && mState != M_PLAY; i++)
      frame(8'h00);
    chk("lockPlay", 16'(currScreen), 16'h2);

    cyc(1'b0, 8'h28);
    frame(8'h28);
    chk("doneEntry", 16'(currScreen), 16'h7);
    repeat (179) frame(8'h00);
    chk("doneHeld", 16'(currScreen), 16'h7);
    frame(8'h00);
    chk("doneExit", 16'(currScreen), 16'h0);

    cyc(1'b0, 8'h28);
    cyc(1'b0, 8'h29);
    cyc(1'b1, 8'h00);
    chk("escWins", 16'(currScreen), 16'h0);
    frame(8'h00);
    chk("pendCleared", 16'(currScreen), 16'h0);

    cyc(1'b0, 8'h28);
    frame(8'h28);
    goToPlay();
    frame(8'h00);
    cyc(1'b0, 8'h28);
    frame(8'h28);
    chk("done2", 16'(currScreen), 16'h7);
    repeat (49) frame(8'h00);
    cyc(1'b1, 8'h29);
    chk("escDone", 16'(currScreen), 16'h0);

    frame(8'h00);
    cyc(1'b0, 8'h28);
    frame(8'h28);
    repeat (40) frame(8'h07);
    chk("x400", 16'(pickLRx), 16'd400);
    pulseReset();
    chk("rstScreen", 16'(currScreen), 16'h0);
    chk("rstX", 16'(pickLRx), 16'd320);
    chk("rstClose", 16'(close), 16'h0);
    frame(8'h00);
    frame(8'h00);
    chk("stayTitle", 16'(currScreen), 16'h0);
    cyc(1'b0, 8'h28);
    frame(8'h28);
    chk("reEnter", 16'(currScreen), 16'h1);

    rk = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        rk = keyTab[$urandom_range(0, 7)];
      if ($urandom_range(0, 299) == 0)
        pulseReset();
      else
        cyc($urandom_range(0, 2) == 0, rk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
